sh4a_regfile_port: RTL and testbench
====================================

Name: sh4a_regfile_port

Overview:
- Client-side sequencer for the SH4A register file; drives its two read-index ports and its write port.
- Sits between decode and execute. Accepts decoded instructions, fetches two source operands with the regfile's 1-cycle registered read latency, and hands operands to execute.
- Tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
- Forwards execute writebacks onto the regfile write port.

Parameters:
- TAG_W, 32, width of the opaque instruction payload passed from decode to execute.
- NUM_REGS, 24, number of legal register indices (0..NUM_REGS-1); sets the scoreboard width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  instruction accepted this cycle
- in_rs0 / in_rs1  in  5  source register indices
- in_rd  in  5  destination index
- in_rd_valid  in  1  instruction writes in_rd
- in_tag  in  TAG_W  payload
- out_valid  out  1  operands available to execute
- out_ready  in  1  execute takes operands
- out_op0 / out_op1  out  32  source operand values
- out_rd  out  5  latched destination index
- out_rd_valid  out  1  latched destination-valid flag
- out_tag  out  TAG_W  latched payload
- wb_valid  in  1  execute writeback (always accepted)
- wb_idx  in  5  writeback index
- wb_data  in  32  writeback data
- idx_read0 / idx_read1  out  5  to regfile read indices
- reg_read0 / reg_read1  in  32  from regfile, registered (valid the cycle after the index is presented)
- idx_write  out  5  to regfile
- reg_write  out  32  to regfile
- reg_write_enable  out  1  to regfile
- busy_mask  out  NUM_REGS  scoreboard state
- port_idle  out  1  FSM in IDLE and busy_mask == 0

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE, busy_mask=0, out_valid=0, out_op0/out_op1/out_tag=0, out_rd=0, out_rd_valid=0. in_ready=0 while reset is asserted.
- The regfile ignores reads during reset; no operand is captured until after the first IDLE cycle following reset.
- FSM states: IDLE, READ, HOLD. At most one instruction is in flight.
- Hazard: hz = busy[in_rs0] | busy[in_rs1] | (in_rd_valid & busy[in_rd]). REG_ZERO is never busy.
- IDLE:
  - in_ready = !hz.
  - idx_read0/1 = in_rs0/in_rs1, driven combinationally.
  - On handshake: latch in_rd, in_rd_valid, in_tag; go to READ.
- READ: capture reg_read0/1 into out_op0/1; go to HOLD.
- HOLD:
  - out_valid = 1; outputs stay stable until out_ready.
  - On out_valid & out_ready: go to IDLE. If out_rd_valid and out_rd != REG_ZERO, set busy[out_rd].
- Latency: input handshake at cycle N gives out_valid at N+2. Peak throughput is 1 instruction per 3 cycles.
- Write port is combinational pass-through: reg_write_enable = wb_valid, idx_write = wb_idx, reg_write = wb_data.
- On wb_valid, clear busy[wb_idx] at the same clock edge as the regfile commit.
- Simultaneous set and clear of the same index cannot occur: WAW stall keeps the destination non-busy at issue. If it does occur, set wins (assertion failure).
- Writeback while in READ/HOLD cannot target a captured source, because sources were non-busy at issue.
- wb_idx must be < NUM_REGS. wb_valid to a non-busy index other than REG_ZERO is an assertion failure.
- Reset mid-operation: the in-flight instruction is discarded and the scoreboard is cleared.

Optional Feature:
- Macro: SH4A_REGFILE_PORT_FORWARD_EN.
- With the macro: in IDLE, a busy source whose index equals wb_idx with wb_valid high in the same cycle is not a hazard. Its operand is taken from wb_data, latched at the handshake, and substituted in READ for the regfile output, which still holds the old value.
- Without the macro: that case stalls one cycle, and the regfile supplies the value afterward.

Decomposition:
- Shared include sh4a_registers.vh holds:
  - REG_ZERO and the register-index width (5).
  - NUM_REGS default.
  - FSM state encodings (2 bits).
- Sub-module sh4a_scoreboard: NUM_REGS busy bits with set/clear ports and two-source/one-destination hazard lookup, with REG_ZERO masked.

Test Plan:
- Reset, then load regfile r3=0x1234_5678 via wb. Issue rs0=3, rs1=REG_ZERO, rd_valid=0 -> out_valid 2 cycles after handshake; op0=0x12345678, op1=0.
- Issue rd=5 and take it (out_ready=1). Then offer rs0=5 -> in_ready=0 until wb_valid idx=5 data=0xCAFEF00D; next instruction then reads 0xCAFEF00D.
- Offer WAW (in_rd=5 while busy[5]) -> stall until wb idx=5. busy_mask bit5 goes 1 then 0; port_idle=1 afterward.
- Hold out_ready=0 for 4 cycles in HOLD -> out_op0/1, out_tag stable and in_ready=0; release -> one handshake only.
- With SH4A_REGFILE_PORT_FORWARD_EN: busy r7, offer rs1=7 in the same cycle as wb idx=7 data=0xDEADBEEF -> handshake that cycle, op1=0xDEADBEEF. Without the macro -> handshake one cycle later, same value.
- Assert reset while in HOLD -> out_valid=0 and busy_mask=0 immediately (async); after release, a normal issue completes.

Source files
------------

// File: rtl/sh4a_regfile_port_pkg.sv
// ---------------------------------------------------------------------------
// sh4a_regfile_port_pkg
//   Shared definitions for the SH4A register-file client port:
//   register-index width, the hard-wired zero register, the default
//   register count, operand width and the 2-bit sequencer state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package sh4a_regfile_port_pkg;

    localparam int IDX_W            = 5;
    localparam int DATA_W           = 32;
    localparam int NUM_REGS_DEFAULT = 24;

    localparam logic [IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_HOLD = 2'b10
    } port_state_e;

    // REG_ZERO is hard-wired and never tracked as busy.
    function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/sh4a_regfile_port_scoreboard.sv
// ---------------------------------------------------------------------------
// sh4a_regfile_port_scoreboard
//   One busy bit per architectural register. A bit is set when an
//   instruction with a destination retires to execute and cleared when
//   execute writes that register back. Provides busy lookups for two
//   sources and one destination; REG_ZERO always reads as not busy.
//
//   Ports:
//     clk_i, reset_i      clock, asynchronous active-high reset
//     set_i, set_idx_i    mark a destination as pending
//     clr_i, clr_idx_i    writeback clears a pending destination
//     rs0_idx_i/rs1_idx_i source indices to look up
//     rd_idx_i            destination index to look up
//     rs0_busy_o/rs1_busy_o/rd_busy_o  lookup results
//     busy_mask_o         full scoreboard state
// ---------------------------------------------------------------------------
module sh4a_regfile_port_scoreboard
    import sh4a_regfile_port_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                set_i,
    input  logic [IDX_W-1:0]    set_idx_i,
    input  logic                clr_i,
    input  logic [IDX_W-1:0]    clr_idx_i,
    input  logic [IDX_W-1:0]    rs0_idx_i,
    input  logic [IDX_W-1:0]    rs1_idx_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic                rs0_busy_o,
    output logic                rs1_busy_o,
    output logic                rd_busy_o,
    output logic [NUM_REGS-1:0] busy_mask_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Out-of-range indices and REG_ZERO look up as not busy.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] mask,
                                     input logic [IDX_W-1:0]    idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i) && !is_zero_reg(idx)) begin
                hit = mask[i];
            end
        end
        return hit;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_i && clr_idx_i == IDX_W'(i)) begin
                busy_d[i] = 1'b0;
            end
            // Applied after the clear so a coincident set wins.
            if (set_i && set_idx_i == IDX_W'(i) && !is_zero_reg(set_idx_i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs0_busy_o  = busy_at(busy_q, rs0_idx_i);
    assign rs1_busy_o  = busy_at(busy_q, rs1_idx_i);
    assign rd_busy_o   = busy_at(busy_q, rd_idx_i);
    assign busy_mask_o = busy_q;

    // Protocol checks on the writeback side.
    always @(posedge clk_i) begin
        if (!reset_i && clr_i) begin
            assert (int'(clr_idx_i) < NUM_REGS);
            assert (is_zero_reg(clr_idx_i) || busy_at(busy_q, clr_idx_i));
            assert (!(set_i && !is_zero_reg(set_idx_i) && set_idx_i == clr_idx_i));
        end
    end

endmodule

// File: rtl/sh4a_regfile_port.sv
// ---------------------------------------------------------------------------
// sh4a_regfile_port
//   Client-side sequencer for the SH4A register file. Accepts one decoded
//   instruction at a time, presents its source indices to the regfile read
//   ports, captures the registered read data one cycle later and holds the
//   operands for execute. A scoreboard stalls issue on RAW/WAW hazards
//   against destinations still awaiting writeback. Execute writebacks pass
//   straight through to the regfile write port.
//
//   Optional feature (macro SH4A_REGFILE_PORT_FORWARD_EN):
//     A busy source being written back in the same IDLE cycle is not a
//     hazard; its value is taken from wb_data_i and substituted for the
//     stale regfile read. Without the macro that case stalls one cycle.
//
//   Ports:
//     clk_i, reset_i                        clock, async active-high reset
//     in_valid_i/in_ready_o                 decode handshake
//     in_rs0_i, in_rs1_i, in_rd_i,
//     in_rd_valid_i, in_tag_i               decoded instruction fields
//     out_valid_o/out_ready_i               execute handshake
//     out_op0_o, out_op1_o                  source operand values
//     out_rd_o, out_rd_valid_o, out_tag_o   latched destination and payload
//     wb_valid_i, wb_idx_i, wb_data_i       execute writeback
//     idx_read0_o, idx_read1_o              regfile read indices
//     reg_read0_i, reg_read1_i              regfile read data (1-cycle)
//     idx_write_o, reg_write_o,
//     reg_write_enable_o                    regfile write port
//     busy_mask_o                           scoreboard state
//     port_idle_o                           IDLE with no pending writes
// ---------------------------------------------------------------------------
module sh4a_regfile_port
    import sh4a_regfile_port_pkg::*;
#(
    parameter int TAG_W    = 32,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic                clk_i,
    input  logic                reset_i,

    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IDX_W-1:0]    in_rs0_i,
    input  logic [IDX_W-1:0]    in_rs1_i,
    input  logic [IDX_W-1:0]    in_rd_i,
    input  logic                in_rd_valid_i,
    input  logic [TAG_W-1:0]    in_tag_i,

    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_op0_o,
    output logic [DATA_W-1:0]   out_op1_o,
    output logic [IDX_W-1:0]    out_rd_o,
    output logic                out_rd_valid_o,
    output logic [TAG_W-1:0]    out_tag_o,

    input  logic                wb_valid_i,
    input  logic [IDX_W-1:0]    wb_idx_i,
    input  logic [DATA_W-1:0]   wb_data_i,

    output logic [IDX_W-1:0]    idx_read0_o,
    output logic [IDX_W-1:0]    idx_read1_o,
    input  logic [DATA_W-1:0]   reg_read0_i,
    input  logic [DATA_W-1:0]   reg_read1_i,

    output logic [IDX_W-1:0]    idx_write_o,
    output logic [DATA_W-1:0]   reg_write_o,
    output logic                reg_write_enable_o,

    output logic [NUM_REGS-1:0] busy_mask_o,
    output logic                port_idle_o
);

    port_state_e         state_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_op0_q;
    logic [DATA_W-1:0]   out_op1_q;
    logic [IDX_W-1:0]    out_rd_q;
    logic                out_rd_valid_q;
    logic [TAG_W-1:0]    out_tag_q;

    logic                rs0_busy;
    logic                rs1_busy;
    logic                rd_busy;
    logic                src0_hz;
    logic                src1_hz;
    logic                hazard;
    logic                handshake;
    logic                retire;
    logic [DATA_W-1:0]   op0_sel;
    logic [DATA_W-1:0]   op1_sel;

    // ------------------------------------------------------------------
    // Scoreboard: set on retire to execute, cleared by writeback.
    // ------------------------------------------------------------------
    sh4a_regfile_port_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .set_i       (retire && out_rd_valid_q),
        .set_idx_i   (out_rd_q),
        .clr_i       (wb_valid_i),
        .clr_idx_i   (wb_idx_i),
        .rs0_idx_i   (in_rs0_i),
        .rs1_idx_i   (in_rs1_i),
        .rd_idx_i    (in_rd_i),
        .rs0_busy_o  (rs0_busy),
        .rs1_busy_o  (rs1_busy),
        .rd_busy_o   (rd_busy),
        .busy_mask_o (busy_mask_o)
    );

`ifdef SH4A_REGFILE_PORT_FORWARD_EN
    // A busy source written back this very cycle can be forwarded: the
    // regfile read issued now still returns the old value, so the
    // writeback data is latched and substituted in READ.
    logic                fwd0_hit;
    logic                fwd1_hit;
    logic                fwd0_q;
    logic                fwd1_q;
    logic [DATA_W-1:0]   fwd_data_q;

    assign fwd0_hit = rs0_busy && wb_valid_i && (wb_idx_i == in_rs0_i);
    assign fwd1_hit = rs1_busy && wb_valid_i && (wb_idx_i == in_rs1_i);
    assign src0_hz  = rs0_busy && !fwd0_hit;
    assign src1_hz  = rs1_busy && !fwd1_hit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fwd0_q     <= 1'b0;
            fwd1_q     <= 1'b0;
            fwd_data_q <= '0;
        end else if (handshake) begin
            fwd0_q     <= fwd0_hit;
            fwd1_q     <= fwd1_hit;
            fwd_data_q <= wb_data_i;
        end
    end

    assign op0_sel = fwd0_q ? fwd_data_q : reg_read0_i;
    assign op1_sel = fwd1_q ? fwd_data_q : reg_read1_i;
`else
    assign src0_hz = rs0_busy;
    assign src1_hz = rs1_busy;
    assign op0_sel = reg_read0_i;
    assign op1_sel = reg_read1_i;
`endif

    // Destination hazard (WAW) is never forwarded: it must drain first.
    assign hazard     = src0_hz || src1_hz || (in_rd_valid_i && rd_busy);
    assign in_ready_o = !reset_i && (state_q == ST_IDLE) && !hazard;
    assign handshake  = in_valid_i && in_ready_o;
    assign retire     = (state_q == ST_HOLD) && out_ready_i;

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> READ (regfile read latency) -> HOLD (until taken)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            out_valid_q    <= 1'b0;
            out_op0_q      <= '0;
            out_op1_q      <= '0;
            out_rd_q       <= '0;
            out_rd_valid_q <= 1'b0;
            out_tag_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        out_rd_q       <= in_rd_i;
                        out_rd_valid_q <= in_rd_valid_i;
                        out_tag_q      <= in_tag_i;
                        state_q        <= ST_READ;
                    end
                end
                ST_READ: begin
                    out_op0_q   <= op0_sel;
                    out_op1_q   <= op1_sel;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_op0_o      = out_op0_q;
    assign out_op1_o      = out_op1_q;
    assign out_rd_o       = out_rd_q;
    assign out_rd_valid_o = out_rd_valid_q;
    assign out_tag_o      = out_tag_q;

    // Read indices follow decode directly; only the IDLE-cycle read matters.
    assign idx_read0_o = in_rs0_i;
    assign idx_read1_o = in_rs1_i;

    assign reg_write_enable_o = wb_valid_i;
    assign idx_write_o        = wb_idx_i;
    assign reg_write_o        = wb_data_i;

    assign port_idle_o = (state_q == ST_IDLE) && (busy_mask_o == '0);

endmodule

// File: tb/tb_sh4a_regfile_port.sv
// ---------------------------------------------------------------------------
// tb_sh4a_regfile_port
//   Directed bench for sh4a_regfile_port with a small behavioural regfile
//   (registered read, read-old-on-collision, r0 hard-wired to zero).
//   Inputs change at/after the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sh4a_regfile_port;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs0;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rd;
    logic        in_rd_valid;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op0;
    logic [31:0] out_op1;
    logic [4:0]  out_rd;
    logic        out_rd_valid;
    logic [31:0] out_tag;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [4:0]  idx_read0;
    logic [4:0]  idx_read1;
    logic [31:0] reg_read0;
    logic [31:0] reg_read1;
    logic [4:0]  idx_write;
    logic [31:0] reg_write;
    logic        reg_write_enable;
    logic [23:0] busy_mask;
    logic        port_idle;

    int errors = 0;
    int checks = 0;

    sh4a_regfile_port #(
        .TAG_W    (32),
        .NUM_REGS (24)
    ) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_rs0_i           (in_rs0),
        .in_rs1_i           (in_rs1),
        .in_rd_i            (in_rd),
        .in_rd_valid_i      (in_rd_valid),
        .in_tag_i           (in_tag),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_op0_o          (out_op0),
        .out_op1_o          (out_op1),
        .out_rd_o           (out_rd),
        .out_rd_valid_o     (out_rd_valid),
        .out_tag_o          (out_tag),
        .wb_valid_i         (wb_valid),
        .wb_idx_i           (wb_idx),
        .wb_data_i          (wb_data),
        .idx_read0_o        (idx_read0),
        .idx_read1_o        (idx_read1),
        .reg_read0_i        (reg_read0),
        .reg_read1_i        (reg_read1),
        .idx_write_o        (idx_write),
        .reg_write_o        (reg_write),
        .reg_write_enable_o (reg_write_enable),
        .busy_mask_o        (busy_mask),
        .port_idle_o        (port_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile: reads return the pre-write value on collision.
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) begin
        if (reg_write_enable && idx_write != 5'd0) rf[idx_write] <= reg_write;
        if (rst) begin
            reg_read0 <= 32'h0;
            reg_read1 <= 32'h0;
        end else begin
            reg_read0 <= (idx_read0 == 5'd0) ? 32'h0 : rf[idx_read0];
            reg_read1 <= (idx_read1 == 5'd0) ? 32'h0 : rf[idx_read1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) -----------------
    task automatic drive_idle();
        in_valid = 1'b0; in_rs0 = '0; in_rs1 = '0; in_rd = '0;
        in_rd_valid = 1'b0; in_tag = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    endtask

    task automatic offer(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic rdv,
                         input logic [31:0] tag);
        in_rs0 = rs0; in_rs1 = rs1; in_rd = rd; in_rd_valid = rdv;
        in_tag = tag; in_valid = 1'b1;
    endtask

    // Offers an instruction and waits (bounded) for the handshake edge.
    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic rdv,
                         input logic [31:0] tag, output bit ok);
        @(negedge clk);
        offer(rs0, rs1, rd, rdv, tag);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Issue, then sample out_valid one and two cycles after the handshake.
    task automatic issue_to_hold(input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic [4:0] rd, input logic rdv,
                                 input logic [31:0] tag, output bit ok,
                                 output logic read_v, output logic hold_v);
        issue(rs0, rs1, rd, rdv, tag, ok);
        @(negedge clk);
        read_v = out_valid;
        @(negedge clk);
        hold_v = out_valid;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic wb(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        wb_valid = 1'b1; wb_idx = idx; wb_data = data;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    // ------------------------------- tests ------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy_mask !== 24'h0) begin
            errors++; $display("FAIL reset_state: out_valid=%b busy=%h expected 0/000000", out_valid, busy_mask);
        end
        checks++;
        if (out_op0 !== 32'h0 || out_op1 !== 32'h0 || out_tag !== 32'h0 ||
            out_rd !== 5'd0 || out_rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: op0=%h op1=%h tag=%h rd=%0d rdv=%b expected all zero",
                               out_op0, out_op1, out_tag, out_rd, out_rd_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || port_idle !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle: in_ready=%b port_idle=%b expected 1/1", in_ready, port_idle);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        wb_valid = 1'b1; wb_idx = 5'd0; wb_data = 32'h55AA_33CC;
        in_rs0 = 5'd6; in_rs1 = 5'd17;
        #1;
        checks++;
        if (reg_write_enable !== 1'b1 || idx_write !== 5'd0 || reg_write !== 32'h55AA_33CC) begin
            errors++; $display("FAIL write_port: we=%b idx=%0d data=%h expected 1/0/55aa33cc",
                               reg_write_enable, idx_write, reg_write);
        end
        checks++;
        if (idx_read0 !== 5'd6 || idx_read1 !== 5'd17) begin
            errors++; $display("FAIL read_index: idx0=%0d idx1=%0d expected 6/17", idx_read0, idx_read1);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0; in_rs0 = '0; in_rs1 = '0;
        #1;
        checks++;
        if (reg_write_enable !== 1'b0) begin
            errors++; $display("FAIL write_enable_off: got %b expected 0", reg_write_enable);
        end
    endtask

    task automatic test_basic_read();
        bit ok; logic rv; logic hv;
        issue_to_hold(5'd0, 5'd0, 5'd3, 1'b1, 32'h1, ok, rv, hv);
        checks++;
        if (!ok || rv !== 1'b0 || hv !== 1'b1) begin
            errors++; $display("FAIL load_r3_issue: ok=%0d read_v=%b hold_v=%b expected 1/0/1", ok, rv, hv);
        end
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000008) begin
            errors++; $display("FAIL r3_busy: got %h expected 000008", busy_mask);
        end
        wb(5'd3, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h0) begin
            errors++; $display("FAIL r3_clear: got %h expected 000000", busy_mask);
        end
        issue_to_hold(5'd3, 5'd0, 5'd0, 1'b0, 32'hA5A5_0001, ok, rv, hv);
        checks++;
        if (!ok || rv !== 1'b0 || hv !== 1'b1) begin
            errors++; $display("FAIL read_latency: ok=%0d read_v=%b hold_v=%b expected 1/0/1", ok, rv, hv);
        end
        checks++;
        if (out_op0 !== 32'h1234_5678 || out_op1 !== 32'h0) begin
            errors++; $display("FAIL read_operands: op0=%h op1=%h expected 12345678/00000000", out_op0, out_op1);
        end
        checks++;
        if (out_tag !== 32'hA5A5_0001 || out_rd_valid !== 1'b0) begin
            errors++; $display("FAIL read_payload: tag=%h rdv=%b expected a5a50001/0", out_tag, out_rd_valid);
        end
        take();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || port_idle !== 1'b1) begin
            errors++; $display("FAIL read_retire: out_valid=%b port_idle=%b expected 0/1", out_valid, port_idle);
        end
    endtask

    task automatic test_raw();
        bit ok; logic rv; logic hv; int hits;
        issue_to_hold(5'd0, 5'd0, 5'd5, 1'b1, 32'h2, ok, rv, hv);
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000020) begin
            errors++; $display("FAIL raw_busy: got %h expected 000020", busy_mask);
        end
        offer(5'd5, 5'd0, 5'd0, 1'b0, 32'h3);
        hits = 0;
        repeat (3) begin
            #1;
            if (in_ready) hits++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (hits !== 0) begin
            errors++; $display("FAIL raw_stall: in_ready high %0d cycles expected 0", hits);
        end
        wb(5'd5, 32'hCAFE_F00D);
        issue_to_hold(5'd5, 5'd5, 5'd0, 1'b0, 32'h4, ok, rv, hv);
        checks++;
        if (!ok || hv !== 1'b1 || out_op0 !== 32'hCAFE_F00D || out_op1 !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL raw_value: ok=%0d hold_v=%b op0=%h op1=%h expected 1/1/cafef00d/cafef00d",
                               ok, hv, out_op0, out_op1);
        end
        take();
    endtask

    task automatic test_waw();
        bit ok; logic rv; logic hv; int hits;
        issue_to_hold(5'd0, 5'd0, 5'd5, 1'b1, 32'h5, ok, rv, hv);
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000020 || port_idle !== 1'b0) begin
            errors++; $display("FAIL waw_busy: busy=%h port_idle=%b expected 000020/0", busy_mask, port_idle);
        end
        offer(5'd0, 5'd0, 5'd5, 1'b1, 32'h6);
        hits = 0;
        repeat (3) begin
            #1;
            if (in_ready) hits++;
            @(negedge clk);
        end
        checks++;
        if (hits !== 0) begin
            errors++; $display("FAIL waw_stall: in_ready high %0d cycles expected 0", hits);
        end
        wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 32'h0000_5555;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL waw_same_cycle_wb: in_ready=%b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy_mask !== 24'h0) begin
            errors++; $display("FAIL waw_release: in_ready=%b busy=%h expected 1/000000", in_ready, busy_mask);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_rd_valid !== 1'b1 || out_tag !== 32'h6) begin
            errors++; $display("FAIL waw_issue: out_valid=%b rd=%0d rdv=%b tag=%h expected 1/5/1/00000006",
                               out_valid, out_rd, out_rd_valid, out_tag);
        end
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000020) begin
            errors++; $display("FAIL waw_rebusy: got %h expected 000020", busy_mask);
        end
        wb(5'd5, 32'h0BAD_C0DE);
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h0 || port_idle !== 1'b1) begin
            errors++; $display("FAIL waw_drain: busy=%h port_idle=%b expected 000000/1", busy_mask, port_idle);
        end
    endtask

    task automatic test_hold_stall();
        bit ok; logic rv; logic hv; int bad; int extra;
        // rd = REG_ZERO with rd_valid set must never mark anything busy.
        issue_to_hold(5'd3, 5'd0, 5'd0, 1'b1, 32'h0BAD_F00D, ok, rv, hv);
        checks++;
        if (!ok || hv !== 1'b1) begin
            errors++; $display("FAIL hold_issue: ok=%0d hold_v=%b expected 1/1", ok, hv);
        end
        offer(5'd0, 5'd0, 5'd0, 1'b0, 32'h7);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid !== 1'b1 || out_op0 !== 32'h1234_5678 || out_op1 !== 32'h0 ||
                out_tag !== 32'h0BAD_F00D || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_stable: %0d unstable cycles expected 0", bad);
        end
        @(negedge clk);
        out_ready = 1'b1;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        out_ready = 1'b0;
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL hold_single_take: out_valid high %0d cycles after take expected 0", extra);
        end
        checks++;
        if (busy_mask !== 24'h0 || port_idle !== 1'b1) begin
            errors++; $display("FAIL zero_reg_not_busy: busy=%h port_idle=%b expected 000000/1", busy_mask, port_idle);
        end
    endtask

    task automatic test_forward();
        bit ok; logic rv; logic hv; logic r0; logic r1; int hs; int exp_hs;
`ifdef SH4A_REGFILE_PORT_FORWARD_EN
        exp_hs = 0;
`else
        exp_hs = 1;
`endif
        issue_to_hold(5'd0, 5'd0, 5'd7, 1'b1, 32'h8, ok, rv, hv);
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000080) begin
            errors++; $display("FAIL fwd_busy: got %h expected 000080", busy_mask);
        end
        @(negedge clk);
        offer(5'd0, 5'd7, 5'd0, 1'b0, 32'h77);
        wb_valid = 1'b1; wb_idx = 5'd7; wb_data = 32'hDEAD_BEEF;
        #1;
        r0 = in_ready;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        if (r0) begin
            in_valid = 1'b0;
            hs = 0;
        end else begin
            @(negedge clk);
            #1;
            r1 = in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            hs = r1 ? 1 : 2;
        end
        checks++;
        if (hs !== exp_hs) begin
            errors++; $display("FAIL fwd_handshake_cycle: got %0d expected %0d", hs, exp_hs);
        end
        @(negedge clk);
        rv = out_valid;
        @(negedge clk);
        checks++;
        if (rv !== 1'b0 || out_valid !== 1'b1 || out_op1 !== 32'hDEAD_BEEF || out_op0 !== 32'h0) begin
            errors++; $display("FAIL fwd_value: read_v=%b hold_v=%b op0=%h op1=%h expected 0/1/00000000/deadbeef",
                               rv, out_valid, out_op0, out_op1);
        end
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h0) begin
            errors++; $display("FAIL fwd_clear: got %h expected 000000", busy_mask);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic rv; logic hv;
        issue_to_hold(5'd0, 5'd0, 5'd9, 1'b1, 32'h9, ok, rv, hv);
        take();
        @(negedge clk);
        checks++;
        if (busy_mask !== 24'h000200) begin
            errors++; $display("FAIL mid_busy: got %h expected 000200", busy_mask);
        end
        issue_to_hold(5'd3, 5'd0, 5'd0, 1'b0, 32'h99, ok, rv, hv);
        checks++;
        if (!ok || hv !== 1'b1) begin
            errors++; $display("FAIL mid_hold: ok=%0d hold_v=%b expected 1/1", ok, hv);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy_mask !== 24'h0 || out_op0 !== 32'h0 || out_tag !== 32'h0) begin
            errors++; $display("FAIL mid_async_reset: out_valid=%b busy=%h op0=%h tag=%h expected 0/000000/0/0",
                               out_valid, busy_mask, out_op0, out_tag);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (port_idle !== 1'b1) begin
            errors++; $display("FAIL mid_release_idle: got %b expected 1", port_idle);
        end
        issue_to_hold(5'd3, 5'd3, 5'd0, 1'b0, 32'hAB, ok, rv, hv);
        checks++;
        if (!ok || rv !== 1'b0 || hv !== 1'b1 ||
            out_op0 !== 32'h1234_5678 || out_op1 !== 32'h1234_5678 || out_tag !== 32'hAB) begin
            errors++; $display("FAIL mid_reissue: ok=%0d rv=%b hv=%b op0=%h op1=%h tag=%h expected 1/0/1/12345678/12345678/000000ab",
                               ok, rv, hv, out_op0, out_op1, out_tag);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_basic_read();
        test_raw();
        test_waw();
        test_hold_stall();
        test_forward();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
